// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// saturation on overflow and optional leading-zero blanking for 7-seg decoders.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4,
  parameter int unsigned LZB    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  // Decimal digits needed to hold 2^w-1.
  function automatic int unsigned dec_digits(input int unsigned w);
    longint unsigned v;
    int unsigned     n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    for (int k = 0; k < 8; k++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        n = n + 1;
      end
    end
    return n;
  endfunction

  // 10^d - 1, the largest value representable in d decimal digits.
  function automatic longint unsigned max_dec(input int unsigned d);
    longint unsigned p;
    p = 64'd1;
    for (int k = 0; k < 8; k++) begin
      if (k < int'(d)) p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  localparam int unsigned NEED_D = dec_digits(BIN_W);
  localparam int unsigned ACC_D  = (NEED_D > DIGITS) ? NEED_D : DIGITS;
  localparam int unsigned ACC_W  = 4 * ACC_D;
  localparam int unsigned OUT_W  = 4 * DIGITS;
  localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
  localparam logic [63:0] MAX_VAL = 64'(max_dec(DIGITS));

  // Zero result as it appears after blanking.
  function automatic logic [OUT_W-1:0] rst_bcd();
    logic [OUT_W-1:0] r;
    r = '0;
    if (LZB != 0) begin
      for (int i = 1; i < int'(DIGITS); i++) r[4*i +: 4] = 4'hF;
    end
    return r;
  endfunction

  localparam logic [OUT_W-1:0] RST_BCD = rst_bcd();

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state;
  logic [BIN_W-1:0]   r_bin;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_pend;
  logic               r_busy;
  logic               r_done;
  logic               r_overflow;
  logic [OUT_W-1:0]   r_bcd;

  logic [ACC_W-1:0]   w_acc_adj;
  logic [OUT_W-1:0]   w_bcd_fmt;
  logic               w_lead;
  logic               w_accept;

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd_out  = r_bcd;
  assign overflow = r_overflow;

  // Start is honoured whenever not shifting (IDLE or the DONE cycle).
  assign w_accept = start && (r_state != S_SHIFT);

  // Add-3 correction on every accumulator nibble that is 5 or more.
  always_comb begin
    w_acc_adj = r_acc;
    for (int i = 0; i < int'(ACC_D); i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
    end
  end

  // Final result: saturate on overflow, otherwise blank leading zeros above digit 0.
  always_comb begin
    w_bcd_fmt = r_acc[OUT_W-1:0];
    w_lead    = 1'b1;
    if (r_ovf_pend) begin
      for (int i = 0; i < int'(DIGITS); i++) w_bcd_fmt[4*i +: 4] = 4'h9;
    end else if (LZB != 0) begin
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
        if (w_lead && (w_bcd_fmt[4*i +: 4] == 4'h0)) w_bcd_fmt[4*i +: 4] = 4'hF;
        else w_lead = 1'b0;
      end
    end
  end

  // Conversion FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bin      <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_bcd      <= RST_BCD;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
        end
        S_SHIFT: begin
          r_acc <= {w_acc_adj[ACC_W-2:0], r_bin[BIN_W-1]};
          r_bin <= {r_bin[BIN_W-2:0], 1'b0};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(BIN_W - 1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
          end
        end
        S_DONE: begin
          r_done     <= 1'b1;
          r_bcd      <= w_bcd_fmt;
          r_overflow <= r_ovf_pend;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Accepting a new request overrides the return to IDLE.
      if (w_accept) begin
        r_bin      <= bin_in;
        r_acc      <= '0;
        r_cnt      <= '0;
        r_ovf_pend <= (64'(bin_in) > MAX_VAL);
        r_state    <= S_SHIFT;
        r_busy     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: blanking (LZB=1) and unblanked (LZB=0) instances.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic [13:0] bin_in;
  logic        start;
  logic        busy,  done,  overflow;
  logic [15:0] bcd_out;
  logic        busy0, done0, overflow0;
  logic [15:0] bcd_out0;

  int n_tot = 0;
  int n_bad = 0;

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4), .LZB(1)) u_dut (
    .clk(clk), .rst(rst), .bin_in(bin_in), .start(start),
    .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
  );

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4), .LZB(0)) u_dut0 (
    .clk(clk), .rst(rst), .bin_in(bin_in), .start(start),
    .busy(busy0), .done(done0), .bcd_out(bcd_out0), .overflow(overflow0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // One conversion with start pulsed for a single cycle; checks latency, busy length, results.
  task automatic do_conv(input string tag, input logic [13:0] v, input logic [15:0] e1,
                         input logic [15:0] e0, input logic eov);
    int lat;
    int nb;
    lat = 0;
    nb  = 0;
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (busy) nb++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) nb++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd15);
    check({tag, ".busy_cycles"}, 32'(nb), 32'd14);
    check({tag, ".bcd_lzb1"}, 32'(bcd_out), 32'(e1));
    check({tag, ".bcd_lzb0"}, 32'(bcd_out0), 32'(e0));
    check({tag, ".ovf"}, 32'(overflow), 32'(eov));
    check({tag, ".done0"}, 32'(done0), 32'd1);
    @(posedge clk);
    #1;
    check({tag, ".done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    int ndone;
    int t1;
    int t2;
    logic [15:0] r1;
    logic [15:0] r2;

    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.ovf", 32'(overflow), 32'd0);
    check("rst.bcd_lzb1", 32'(bcd_out), 32'h0000_FFF0);
    check("rst.bcd_lzb0", 32'(bcd_out0), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic values, blanking and saturation boundaries.
    do_conv("zero",  14'd0,     16'hFFF0, 16'h0000, 1'b0);
    do_conv("v1234", 14'd1234,  16'h1234, 16'h1234, 1'b0);
    do_conv("v7",    14'd7,     16'hFFF7, 16'h0007, 1'b0);
    do_conv("v9999", 14'd9999,  16'h9999, 16'h9999, 1'b0);
    do_conv("v10000",14'd10000, 16'h9999, 16'h9999, 1'b1);
    do_conv("v16383",14'd16383, 16'h9999, 16'h9999, 1'b1);
    do_conv("v100",  14'd100,   16'hF100, 16'h0100, 1'b0);

    // Start pulsed mid-conversion must be ignored.
    @(negedge clk);
    bin_in = 14'd42;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) begin
        bin_in = 14'd555;
        start  = 1'b1;
      end
      if (k == 6) start = 1'b0;
      if (done) ndone++;
    end
    check("mid.done_count", 32'(ndone), 32'd1);
    check("mid.bcd", 32'(bcd_out), 32'h0000_FF42);
    check("mid.ovf", 32'(overflow), 32'd0);

    // Back-to-back conversions with start held high.
    @(negedge clk);
    bin_in = 14'd305;
    start  = 1'b1;
    @(posedge clk);
    #1 bin_in = 14'd4096;
    t1 = 0;
    t2 = 0;
    r1 = '0;
    r2 = '0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (t1 == 0) begin
          t1 = k;
          r1 = bcd_out;
        end else if (t2 == 0) begin
          t2 = k;
          r2 = bcd_out;
        end
      end
      if (k == 15) start = 1'b0;
    end
    check("b2b.first_lat", 32'(t1), 32'd15);
    check("b2b.period", 32'(t2 - t1), 32'd15);
    check("b2b.first_bcd", 32'(r1), 32'h0000_F305);
    check("b2b.second_bcd", 32'(r2), 32'h0000_4096);

    // Overflow result left pending so reset has something to clear.
    do_conv("v12345", 14'd12345, 16'h9999, 16'h9999, 1'b1);

    // Reset in the middle of a conversion aborts it.
    @(negedge clk);
    bin_in = 14'd8888;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.bcd", 32'(bcd_out), 32'h0000_FFF0);
    check("abort.ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    check("abort.no_done", 32'(ndone), 32'd0);
    do_conv("after", 14'd1234, 16'h1234, 16'h1234, 1'b0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
